// File: rtl/axi_apb_bridge_mux.sv
// AXI4-Lite slave to multi-completer APB bridge.
// One transaction in flight; the target completer is picked from an address field,
// with DECERR for unmapped slots, a PREADY timeout, and alternating read/write priority.
module axi_apb_bridge_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  // AXI4-Lite write address / data / response
  input  logic [ADDR_W-1:0]           awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W/8-1:0]         wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  // AXI4-Lite read address / data
  input  logic [ADDR_W-1:0]           araddr,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [DATA_W-1:0]           rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid,
  input  logic                        rready,
  // APB requester side
  output logic [NUM_SLV-1:0]          psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  output logic [DATA_W/8-1:0]         pstrb,
  input  logic [NUM_SLV*DATA_W-1:0]   prdata,
  input  logic [NUM_SLV-1:0]          pready,
  input  logic [NUM_SLV-1:0]          pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W:0]   SLV_LIM = (IDX_W+1)'(NUM_SLV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state;
  logic               last_wr;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   sel_idx;

  // request arbitration (only meaningful in IDLE)
  logic               wr_cand, rd_cand, grant_wr, grant_rd;
  logic [ADDR_W-1:0]  req_addr;
  logic [IDX_W-1:0]   req_idx;
  logic               req_hit;
  logic [NUM_SLV-1:0] dec_onehot;

  // selected completer view
  logic [NUM_SLV-1:0][DATA_W-1:0] prdata_v;
  logic               sel_rdy, sel_err, acc_done;
  logic [DATA_W-1:0]  sel_data, acc_data;
  logic [1:0]         acc_resp;

  // AW and W only ever travel together; on contention the direction not granted last wins
  assign wr_cand  = awvalid && wvalid;
  assign rd_cand  = arvalid;
  assign grant_wr = (state == IDLE) && wr_cand && (!rd_cand || !last_wr);
  assign grant_rd = (state == IDLE) && rd_cand && (!wr_cand ||  last_wr);

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;

  assign req_addr = grant_wr ? awaddr : araddr;
  assign req_idx  = req_addr[SEL_LSB +: IDX_W];
  assign req_hit  = ({1'b0, req_idx} < SLV_LIM);

  // one-hot select for the requested slot
  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++)
      dec_onehot[i] = (req_idx == IDX_W'(i));
  end

  assign prdata_v = prdata;
  assign sel_rdy  = pready[sel_idx];
  assign sel_err  = pslverr[sel_idx];
  assign sel_data = prdata_v[sel_idx];

  // ACCESS outcome: completion (ok/slverr) or timeout abort, which reports as SLVERR with no data
  assign acc_done = sel_rdy || (cnt == CNT_MAX);
  assign acc_resp = (!sel_rdy || sel_err) ? RESP_SLVERR : RESP_OKAY;
  assign acc_data = (sel_rdy && !sel_err) ? sel_data : '0;

  // transaction FSM; all APB and response outputs are registered here
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      last_wr <= 1'b0;
      cnt     <= '0;
      sel_idx <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      rvalid  <= 1'b0;
      rresp   <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            last_wr <= grant_wr;
            pwrite  <= grant_wr;
            paddr   <= req_addr;
            sel_idx <= req_idx;
            cnt     <= '0;
            if (grant_wr) begin
              pwdata <= wdata;
              pstrb  <= wstrb;
            end else begin
              pstrb  <= '0;
            end
            if (req_hit) begin
              psel  <= dec_onehot;
              state <= SETUP;
            end else begin
              // unmapped slot: answer directly, no APB cycle
              state <= RESP;
              if (grant_wr) begin
                bvalid <= 1'b1;
                bresp  <= RESP_DECERR;
              end else begin
                rvalid <= 1'b1;
                rresp  <= RESP_DECERR;
                rdata  <= '0;
              end
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (acc_done) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= RESP;
            if (pwrite) begin
              bvalid <= 1'b1;
              bresp  <= acc_resp;
            end else begin
              rvalid <= 1'b1;
              rresp  <= acc_resp;
              rdata  <= acc_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if ((bvalid && bready) || (rvalid && rready)) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_apb_bridge_mux.sv
// Scoreboard bench for axi_apb_bridge_mux: stimulus tasks push expected responses
// (resp, data, arrival cycle) at grant time; B/R monitors pop and compare on handshake.
module tb_axi_apb_bridge_mux;

  logic        aclk = 1'b0;
  logic        areset_n;
  always #5 aclk = ~aclk;

  // main DUT: 4 slots, TIMEOUT 16
  logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata;
  logic [3:0]  wstrb, pstrb, psel, pready, pslverr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, penable, pwrite;
  logic [1:0]  bresp, rresp;
  logic [127:0] prdata;

  axi_apb_bridge_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT(16)) u_dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // second DUT with 3 slots, used for the unmapped-address read
  logic [31:0] araddr3, rdata3, paddr3, pwdata3;
  logic        arvalid3, arready3, rvalid3, rready3, awready3, wready3, bvalid3, penable3, pwrite3;
  logic [1:0]  bresp3, rresp3;
  logic [2:0]  psel3;
  logic [3:0]  pstrb3;

  axi_apb_bridge_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT(16)) u_dut3 (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(32'h0), .awvalid(1'b0), .awready(awready3),
    .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(wready3),
    .bresp(bresp3), .bvalid(bvalid3), .bready(1'b1),
    .araddr(araddr3), .arvalid(arvalid3), .arready(arready3),
    .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .pstrb(pstrb3), .prdata(96'h0), .pready(3'b000), .pslverr(3'b000)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // APB completer models: wait_cfg wait states, err_cfg raises pslverr, rd_cfg read data
  int          wait_cfg[4];
  logic        err_cfg[4];
  logic [31:0] rd_cfg[4];
  int          wcnt[4];
  logic [31:0] cap_wdata, cap_addr;
  logic [3:0]  cap_strb;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      pready[i]          = psel[i] && penable && (wcnt[i] >= wait_cfg[i]);
      pslverr[i]         = psel[i] && penable && err_cfg[i];
      prdata[i*32 +: 32] = rd_cfg[i];
    end
  end

  always @(posedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (psel[i] && penable && !pready[i]) wcnt[i] <= wcnt[i] + 1;
      else wcnt[i] <= 0;
      if (psel[i] && penable && pready[i]) begin
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
        cap_addr  <= paddr;
      end
    end
  end

  // scoreboard queues
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t bq[$];
  exp_t rq[$];
  byte  order_q[$];

  // B monitor: remember the cycle bvalid rose, compare on handshake
  logic b_act = 1'b0;
  int   b_rise = 0;
  always begin
    exp_t e;
    @(negedge aclk); #2;
    if (!areset_n) b_act = 1'b0;
    else begin
      if (bvalid && !b_act) begin b_act = 1'b1; b_rise = cyc; end
      if (bvalid && bready) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          e = bq.pop_front();
          chk("bresp", bresp, e.resp);
          chk("b_cycle", b_rise, e.cyc);
        end
        b_act = 1'b0;
      end
    end
  end

  // R monitor
  logic r_act = 1'b0;
  int   r_rise = 0;
  always begin
    exp_t e;
    @(negedge aclk); #2;
    if (!areset_n) r_act = 1'b0;
    else begin
      if (rvalid && !r_act) begin r_act = 1'b1; r_rise = cyc; end
      if (rvalid && rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          e = rq.pop_front();
          chk("rresp", rresp, e.resp);
          chk("rdata", rdata, e.data);
          chk("r_cycle", r_rise, e.cyc);
        end
        r_act = 1'b0;
      end
    end
  end

  // at most one select line at a time
  always @(negedge aclk) if (psel != 4'b0) chk("psel_onehot", $countones(psel), 1);

  // write request; called at a negedge, returns at the negedge after the grant
  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] er, input int lat, input bit push, output int t);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (awready && wready) begin
        t = cyc;
        if (push) bq.push_back('{er, 32'h0, cyc + lat});
        order_q.push_back(8'h57);
        break;
      end
      @(negedge aclk);
    end
    if (t < 0) fail("wr_grant");
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic rd_req(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed,
                        input int lat, output int t);
    araddr = a; arvalid = 1'b1;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (arready) begin
        t = cyc;
        rq.push_back('{er, ed, cyc + lat});
        order_q.push_back(8'h52);
        break;
      end
      @(negedge aclk);
    end
    if (t < 0) fail("rd_grant");
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 100 && (bq.size() != 0 || rq.size() != 0); k++) @(negedge aclk);
    @(negedge aclk);
    chk(nm, bq.size() + rq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int ta, tb2, tc, td, pen_cnt, bv_seen;
    areset_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    araddr3 = '0; arvalid3 = 1'b0; rready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin wait_cfg[i] = 0; err_cfg[i] = 1'b0; rd_cfg[i] = 32'h0; end

    // reset state
    repeat (3) @(negedge aclk);
    chk("rst_psel", psel, 4'h0);
    chk("rst_penable", penable, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", rdata, 0);
    areset_n = 1'b1;
    @(negedge aclk);

    // zero-wait write to slave 1
    wr_req(32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 2'b00, 3, 1'b1, ta);
    chk("t1_psel_setup", psel, 4'b0010);
    chk("t1_penable_setup", penable, 0);
    chk("t1_paddr", paddr, 32'h0000_1004);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 32'hA5A5_5A5A);
    @(negedge aclk);
    chk("t1_penable_access", penable, 1);
    chk("t1_psel_access", psel, 4'b0010);
    drain("t1_drain");
    chk("t1_cap_wdata", cap_wdata, 32'hA5A5_5A5A);
    chk("t1_cap_strb", cap_strb, 4'hF);

    // read slave 3 with two wait states
    wait_cfg[3] = 2; rd_cfg[3] = 32'hDEAD_BEEF;
    rd_req(32'h0000_3000, 2'b00, 32'hDEAD_BEEF, 5, ta);
    drain("t2_drain");
    chk("t2_pstrb", pstrb, 4'h0);
    chk("t2_pwrite", pwrite, 0);

    // unmapped slot on the 3-slot bridge
    araddr3 = 32'h0000_3000; arvalid3 = 1'b1; ta = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (arready3) begin ta = cyc; break; end
      @(negedge aclk);
    end
    if (ta < 0) fail("t3_grant");
    @(negedge aclk);
    arvalid3 = 1'b0;
    chk("t3_psel", psel3, 3'b000);
    chk("t3_rvalid", rvalid3, 1);
    chk("t3_cycle", cyc, ta + 1);
    chk("t3_rresp", rresp3, 2'b11);
    chk("t3_rdata", rdata3, 0);
    @(negedge aclk);
    chk("t3_rvalid_clear", rvalid3, 0);

    // write slave 0, one wait state, partial strobes
    wait_cfg[0] = 1;
    wr_req(32'h0000_0008, 32'h1122_3344, 4'h3, 2'b00, 4, 1'b1, ta);
    drain("t4_drain");
    chk("t4_cap_strb", cap_strb, 4'h3);
    chk("t4_cap_addr", cap_addr, 32'h0000_0008);

    // slave 2 never ready: timeout after exactly 16 ACCESS cycles
    wait_cfg[2] = 1000;
    wr_req(32'h0000_2000, 32'h0000_0055, 4'hF, 2'b10, 18, 1'b1, ta);
    pen_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bvalid) break;
      if (penable) pen_cnt++;
      @(negedge aclk);
    end
    chk("t5_penable_cycles", pen_cnt, 16);
    chk("t5_psel_cleared", psel, 4'h0);
    drain("t5_drain");

    // slave 0 errors a read
    wait_cfg[0] = 0; err_cfg[0] = 1'b1; rd_cfg[0] = 32'h1234_5678;
    rd_req(32'h0000_0010, 2'b10, 32'h0, 3, ta);
    drain("t6_drain");
    err_cfg[0] = 1'b0;

    // continuous writes and reads alternate, write first after a read
    order_q.delete();
    fork
      begin
        wr_req(32'h0000_1010, 32'hCAFE_0001, 4'hF, 2'b00, 3, 1'b1, ta);
        wr_req(32'h0000_0020, 32'hCAFE_0002, 4'hF, 2'b00, 3, 1'b1, tb2);
      end
      begin
        rd_req(32'h0000_3004, 2'b00, 32'hDEAD_BEEF, 5, tc);
        rd_req(32'h0000_0024, 2'b00, 32'h1234_5678, 3, td);
      end
    join
    drain("t7_drain");
    chk("t7_order_len", order_q.size(), 4);
    chk("t7_order0", order_q[0], 8'h57);
    chk("t7_order1", order_q[1], 8'h52);
    chk("t7_order2", order_q[2], 8'h57);
    chk("t7_order3", order_q[3], 8'h52);

    // bready held low: B stays stable and the pending read is not granted
    rd_cfg[1] = 32'h600D_D00D;
    bready = 1'b0;
    fork
      wr_req(32'h0000_1000, 32'h0BAD_F00D, 4'hF, 2'b00, 3, 1'b1, ta);
      rd_req(32'h0000_1008, 2'b00, 32'h600D_D00D, 3, tb2);
      begin
        for (int k = 0; k < 20; k++) begin
          if (bvalid) break;
          @(negedge aclk);
        end
        repeat (5) begin
          chk("t8_bvalid_held", bvalid, 1);
          chk("t8_bresp_held", bresp, 2'b00);
          chk("t8_arready_blocked", arready, 0);
          @(negedge aclk);
        end
        bready = 1'b1;
      end
    join
    drain("t8_drain");

    // reset in the middle of ACCESS
    wait_cfg[2] = 1000;
    wr_req(32'h0000_2004, 32'h0000_0077, 4'hF, 2'b00, 0, 1'b0, ta);
    @(negedge aclk);
    chk("t9_penable_before", penable, 1);
    #2 areset_n = 1'b0;
    #1;
    chk("t9_psel_async", psel, 4'h0);
    chk("t9_penable_async", penable, 0);
    chk("t9_bvalid_async", bvalid, 0);
    @(negedge aclk);
    areset_n = 1'b1;
    bv_seen = 0;
    repeat (5) begin
      @(negedge aclk);
      if (bvalid) bv_seen++;
    end
    chk("t9_no_response", bv_seen, 0);
    rd_req(32'h0000_1000, 2'b00, 32'h600D_D00D, 3, ta);
    drain("t9_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_apb_bridge_mux.md
# axi_apb_bridge_mux

Parametrised AXI4-Lite-to-APB bridge with built-in slave decode. It serves one AXI4-Lite slave port and drives NUM_SLV APB completers; the UART APB bridge is one of them, alongside future peripheral blocks. It adds several things to the single-target bridge:
- address-decoded PSEL fan-out and per-slave PRDATA/PREADY/PSLVERR muxing;
- PSLVERR propagation to BRESP/RRESP;
- a PREADY timeout;
- DECERR for unmapped addresses;
- fair read/write arbitration.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- NUM_SLV, 4, number of APB completers (1..16)
- SEL_LSB, 12, LSB of slave index field; index = addr[SEL_LSB +: IDX_W], IDX_W = max(1, clog2(NUM_SLV))
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (>=2)

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset, asynchronous, active-low
- awaddr  in  ADDR_W  write address
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  B handshake
- araddr  in  ADDR_W  read address
- arvalid / arready  in / out  1  AR handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  R handshake
- psel  out  NUM_SLV  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  DATA_W/8  APB strobes
- prdata  in  NUM_SLV*DATA_W  slave i occupies [i*DATA_W +: DATA_W]
- pready  in  NUM_SLV  per-slave ready
- pslverr  in  NUM_SLV  per-slave error

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.

IDLE:
- Write candidate requires awvalid && wvalid. AW and W are always accepted together, never separately.
- Read candidate requires arvalid.
- Both candidates present: grant the direction opposite to the last granted (register last_wr, reset 0, so a write wins first).
- Granted write: awready = wready = 1 combinationally in that cycle. Latch awaddr, wdata, wstrb; pwrite = 1.
- Granted read: arready = 1. Latch araddr; pwrite = 0; pstrb = 0.
- Index < NUM_SLV: go to SETUP.
- Index >= NUM_SLV: go to RESP with resp = 2'b11 (DECERR). No APB activity.

SETUP:
- psel[idx] = 1, penable = 0; paddr, pwdata, pstrb stable.
- Always proceeds to ACCESS.

ACCESS:
- psel[idx] = 1, penable = 1.
- Timeout counter starts at 0 and increments each cycle that pready[idx] = 0.
- pready[idx] = 1: transfer completes. resp = pslverr[idx] ? 2'b10 : 2'b00. For reads, rdata = pslverr[idx] ? 0 : prdata slice idx. Go to RESP.
- Counter reaches TIMEOUT-1 with pready still 0: abort. resp = 2'b10, rdata = 0, go to RESP.

RESP:
- psel = 0, penable = 0.
- Write: bvalid = 1, bresp = resp. Read: rvalid = 1, rresp = resp.
- Response held stable until bready/rready. The cycle after the handshake: IDLE, valid = 0.

General rules:
- Only one outstanding transaction; all ready outputs are 0 outside IDLE.
- paddr, pwdata, pstrb, pwrite are held after the transfer until the next grant.
- Only one psel bit is ever set at a time.

## Timing
- All outputs are registered except awready, wready, arready (combinational in IDLE).
- Reset values: all outputs 0, state IDLE, last_wr 0, counter 0.
- Reset asserted mid-transfer: psel, penable, bvalid, rvalid drop to 0 immediately (asynchronous). No response is issued.
- Latency with zero-wait slave, grant at cycle T: SETUP at T+1, ACCESS at T+2, valid at T+3.
- Each slave wait state adds 1 cycle.
- DECERR: valid at T+1.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then valid.
- Back-to-back: the next grant happens no earlier than the cycle after the response handshake.
- pslverr is sampled only when pready[idx] = 1.

## Test plan
- Write to 0x0000_1004, wdata 0xA5A5_5A5A, wstrb 0xF, slave 1 zero-wait → psel = 4'b0010; penable rises one cycle after psel; pwdata = 0xA5A5_5A5A; bvalid at T+3 with bresp 00.
- Read 0x0000_3000, slave 3 returns 0xDEAD_BEEF after 2 wait states → rvalid at T+5, rdata 0xDEAD_BEEF, rresp 00.
- NUM_SLV = 3, read 0x0000_3000 → no psel activity; rvalid at T+1 with rresp 11 and rdata 0.
- Slave 2 holds pready = 0, TIMEOUT = 16 → penable high exactly 16 cycles; then bresp 10 and psel cleared.
- Slave 0 asserts pslverr with pready on a read → rresp 10, rdata 0.
- Simultaneous continuous write and read requests → grants alternate W, R, W, R; bready held 0 for 5 cycles keeps bvalid/bresp stable and blocks arready; areset_n pulsed during ACCESS clears psel/penable in the same cycle.
